// File: rtl/sa_div_seq_if.sv
// sa_div_seq_if: start/busy/done handshake and operand/result bundle for sa_div_seq
// Signals: start, dividend, divisor driven by the master (requester).
//          busy, done, quotient, remainder, div_by_zero driven by the slave (divider).
interface sa_div_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/sa_div_seq.sv
// sa_div_seq: sequential restoring unsigned divider, one quotient bit per clock
// Ports: clk, rst_n (async active-low), bus (slave side of sa_div_seq_if):
//   start/dividend/divisor in; busy (RUN), done (1-cycle pulse),
//   quotient/remainder/div_by_zero out, held until the next completion.
module sa_div_seq #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sa_div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] dq, dvs, r, r_sub, q_r, rem_r;
  logic [WIDTH:0]   r_sh;
  logic [CW-1:0]    cnt;
  logic             ge, dbz_r, last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // A zero divisor skips RUN entirely and completes on the very next cycle.
  always_comb
    state_nx = (state == IDLE) ? (bus.start ? ((|bus.divisor) ? RUN : DONE) : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end
  // The partial remainder after a restoring step is always below the divisor,
  // so only the shifted trial value needs the extra top bit.
  always_comb begin
    last  = (cnt == CW'(1));
    r_sh  = {r, dq[WIDTH-1]};
    ge    = (r_sh >= {1'b0, dvs});
    r_sub = ge ? WIDTH'(r_sh - {1'b0, dvs}) : r_sh[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dq    <= '0;
      dvs   <= '0;
      r     <= '0;
      cnt   <= '0;
      q_r   <= '0;
      rem_r <= '0;
      dbz_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      dq  <= bus.dividend;
      dvs <= bus.divisor;
      r   <= '0;
      cnt <= CW'(WIDTH);
      if (!(|bus.divisor)) begin
        q_r   <= '1;
        rem_r <= bus.dividend;
        dbz_r <= 1'b1;
      end
    end else if (state == RUN) begin
      r   <= r_sub;
      dq  <= {dq[WIDTH-2:0], ge};
      cnt <= cnt - 1'b1;
      if (last) begin
        q_r   <= {dq[WIDTH-2:0], ge};
        rem_r <= r_sub;
        dbz_r <= 1'b0;
      end
    end
  assign bus.quotient    = q_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule
